// File: rtl/jtframe_romrq_pkg.sv
// Shared types and helpers for the jtframe ROM request cache family.
// Holds the FSM state type, the address alignment rule and the line pointer width.
package jtframe_romrq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } romrq_state_t;

  // Number of low address bits that select a lane inside the 32-bit line
  function automatic int align_bits(input int dw);
    if (dw == 8) begin
      return 2;
    end else if (dw == 16) begin
      return 1;
    end else begin
      return 0;
    end
  endfunction

  // wr_ptr width: $clog2(CACHE_N), never below one bit
  function automatic int ptr_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  localparam int PTR_W_DEFAULT = ptr_width(4);

endpackage

// File: rtl/jtframe_romrq_tagmatch.sv
// Parallel tag compare over N lines: hit flag, one-hot match vector and encoded index.
// The lowest matching line wins the encoded index.
module jtframe_romrq_tagmatch #(
  parameter int AW = 18,
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0][AW-1:0] tags,
  input  logic [N-1:0]         valid,
  input  logic [AW-1:0]        key,
  output logic                 hit,
  output logic [N-1:0]         hit_oh,
  output logic [PW-1:0]        hit_idx
);

  // compare every valid line against the key and encode the first match
  always_comb begin
    hit_oh  = '0;
    hit_idx = '0;
    for (int i = 0; i < N; i++) begin
      hit_oh[i] = valid[i] && (tags[i] == key);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (hit_oh[i]) begin
        hit_idx = PW'(i);
      end else begin
        hit_idx = hit_idx;
      end
    end
    hit = |hit_oh;
  end

endmodule

// File: rtl/jtframe_romrq_cache.sv
// Fully-associative 32-bit line cache with FIFO replacement in front of one SDRAM slot.
// A single outstanding fill is tracked by the FSM and lands in the cache even if addr moves.
module jtframe_romrq_cache
  import jtframe_romrq_pkg::*;
#(
  parameter int AW      = 18,
  parameter int DW      = 8,
  parameter int CACHE_N = 4,
  parameter int REPACK  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [21:0]   offset,
  input  logic [AW-1:0] addr,
  input  logic          addr_ok,
  input  logic [31:0]   din,
  input  logic          din_ok,
  input  logic          we,
  output logic          req,
  output logic [21:0]   sdram_addr,
  output logic          data_ok,
  output logic [DW-1:0] dout
);

  localparam int PW = ptr_width(CACHE_N);
  localparam int LB = align_bits(DW);
  localparam logic [AW-1:0] LOW_MASK = AW'((1 << LB) - 1);

  romrq_state_t                   state_r;
  logic [CACHE_N-1:0][AW-1:0]     tag_r;
  logic [CACHE_N-1:0][31:0]       data_r;
  logic [CACHE_N-1:0]             valid_r;
  logic [PW-1:0]                  wr_ptr_r;
  logic [AW-1:0]                  pend_r;
  logic                           drop_r;

  logic [AW-1:0]      areq_s;
  logic               match_s;
  logic               hit_s;
  logic [CACHE_N-1:0] hit_oh_s;
  logic [PW-1:0]      hit_idx_s;
  logic               fill_s;
  logic               pt_s;
  logic [21:0]        pend_ext_s;
  logic [4:0]         lane_s;
  logic [31:0]        src_s;
  logic [31:0]        word_s;

  assign areq_s     = addr & ~LOW_MASK;
  assign hit_s      = match_s && !clr;
  assign fill_s     = (state_r == WAIT) && we && din_ok;
  assign pt_s       = (REPACK == 0) && fill_s && !drop_r && !clr && (pend_r == areq_s);
  assign pend_ext_s = 22'(pend_r);
  // 8-bit consumers address bytes while the slot is addressed in 16-bit words
  assign sdram_addr = ((DW == 8) ? (pend_ext_s >> 1) : pend_ext_s) + offset;

  jtframe_romrq_tagmatch #(
    .AW (AW),
    .N  (CACHE_N),
    .PW (PW)
  ) u_tagmatch (
    .tags    (tag_r),
    .valid   (valid_r),
    .key     (areq_s),
    .hit     (match_s),
    .hit_oh  (hit_oh_s),
    .hit_idx (hit_idx_s)
  );

  // pick the little-endian lane out of the pass-through or cached line
  always_comb begin
    lane_s = 5'd0;
    if (DW == 8) begin
      lane_s = {addr[1:0], 3'b000};
    end else if (DW == 16) begin
      lane_s = {addr[1], 4'b0000};
    end else begin
      lane_s = 5'd0;
    end
    src_s  = pt_s ? din : data_r[hit_idx_s];
    word_s = src_s >> lane_s;
  end

  // request FSM, line fill and invalidation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      req      <= 1'b0;
      pend_r   <= '0;
      drop_r   <= 1'b0;
      valid_r  <= '0;
      wr_ptr_r <= '0;
      tag_r    <= '0;
      data_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (addr_ok && !hit_s && !clr) begin
            pend_r  <= areq_s;
            req     <= 1'b1;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (fill_s) begin
            req     <= 1'b0;
            state_r <= IDLE;
            drop_r  <= 1'b0;
          end else if (clr) begin
            drop_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          req     <= 1'b0;
        end
      endcase
      // clr beats a same-cycle fill, so nothing is written then
      if (clr) begin
        valid_r  <= '0;
        wr_ptr_r <= '0;
      end else if (fill_s && !drop_r) begin
        tag_r[wr_ptr_r]   <= pend_r;
        data_r[wr_ptr_r]  <= din;
        valid_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r <= (wr_ptr_r == PW'(CACHE_N - 1)) ? '0 : wr_ptr_r + 1'b1;
      end
    end
  end

  // registered response: hit or same-edge pass-through of the fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_ok <= 1'b0;
      dout    <= '0;
    end else begin
      data_ok <= addr_ok && (hit_s || pt_s);
      if (addr_ok && (hit_s || pt_s)) begin
        dout <= word_s[DW-1:0];
      end
    end
  end

endmodule
